// File: rtl/memory_bus_ws.sv
// memory_bus_ws: bank-decoding memory router with per-bank wait states,
// optional external ready handshake and a WAIT_EXT timeout that becomes a bus error.
module memory_bus_ws #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BANK_BITS  = 2,
    parameter int unsigned LAT_BITS   = 4,
    parameter logic [(2**BANK_BITS)*LAT_BITS-1:0] BANK_LATENCY = {4'd1, 4'd1, 4'd1, 4'd1},
    parameter logic [(2**BANK_BITS)-1:0]          EXT_READY_MASK = 4'b0100,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                                 raw_clk,
    input  logic                                 reset,
    input  logic [ADDR_WIDTH-1:0]                address,
    input  logic [DATA_WIDTH-1:0]                data_in,
    input  logic [DATA_WIDTH/8-1:0]              write_mask,
    input  logic                                 write_enable,
    input  logic                                 bus_enable,
    output logic [DATA_WIDTH-1:0]                data_out,
    output logic                                 ready,
    output logic                                 bus_error,
    output logic [ADDR_WIDTH-BANK_BITS-1:0]      bank_address,
    output logic [DATA_WIDTH-1:0]                bank_data_in,
    output logic [DATA_WIDTH/8-1:0]              bank_write_mask,
    output logic [(2**BANK_BITS)-1:0]            bank_select,
    output logic [(2**BANK_BITS)-1:0]            bank_write_enable,
    input  logic [(2**BANK_BITS)*DATA_WIDTH-1:0] bank_data_out,
    input  logic [(2**BANK_BITS)-1:0]            bank_ready
);

    localparam int unsigned NUM_BANKS = 2**BANK_BITS;
    localparam int unsigned MASK_W    = DATA_WIDTH/8;
    localparam int unsigned LOW_W     = ADDR_WIDTH-BANK_BITS;
    // Timeout counter only needs to reach TIMEOUT-1
    localparam int unsigned TO_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACCESS   = 2'd1;
    localparam logic [1:0] S_WAIT_EXT = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]            state, state_nx;
    logic [BANK_BITS-1:0]  bank, bank_nx;
    logic                  is_write, is_write_nx;
    logic [LOW_W-1:0]      addr_q, addr_nx;
    logic [DATA_WIDTH-1:0] data_q, data_nx;
    logic [MASK_W-1:0]     mask_q, mask_nx;
    logic [LAT_BITS-1:0]   wait_cnt, wait_nx;
    logic [TO_W-1:0]       tcnt, tcnt_nx;
    logic                  err, err_nx;
    logic [DATA_WIDTH-1:0] data_out_nx;
    logic                  ready_nx;
    logic                  bus_error_nx;
    logic [NUM_BANKS-1:0]  select_nx;
    logic [NUM_BANKS-1:0]  strobe_nx;

    logic [BANK_BITS-1:0]  req_bank;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [LAT_BITS-1:0]   req_lat;
    logic                  bank_ext;

    assign req_bank = address[ADDR_WIDTH-1 -: BANK_BITS];
    assign sel_data = bank_data_out[bank*DATA_WIDTH +: DATA_WIDTH];
    assign req_lat  = BANK_LATENCY[req_bank*LAT_BITS +: LAT_BITS];
    assign bank_ext = EXT_READY_MASK[bank];

    assign bank_address    = addr_q;
    assign bank_data_in    = data_q;
    assign bank_write_mask = mask_q;

    // Next-state, counter and registered-output decode
    always_comb begin
        state_nx     = state;
        bank_nx      = bank;
        is_write_nx  = is_write;
        addr_nx      = addr_q;
        data_nx      = data_q;
        mask_nx      = mask_q;
        wait_nx      = wait_cnt;
        tcnt_nx      = tcnt;
        err_nx       = err;
        data_out_nx  = data_out;
        strobe_nx    = '0;
        select_nx    = '0;
        ready_nx     = 1'b0;
        bus_error_nx = 1'b0;

        case (state)
            S_IDLE: begin
                err_nx = 1'b0;
                if (bus_enable) begin
                    bank_nx     = req_bank;
                    is_write_nx = write_enable;
                    addr_nx     = address[LOW_W-1:0];
                    data_nx     = data_in;
                    mask_nx     = write_mask;
                    wait_nx     = req_lat;
                    state_nx    = S_ACCESS;
                    // The only write strobe of the transaction: first ACCESS cycle
                    if (write_enable) begin
                        strobe_nx = NUM_BANKS'(1) << req_bank;
                    end
                end
            end
            S_ACCESS: begin
                if (wait_cnt != '0) begin
                    wait_nx = wait_cnt - LAT_BITS'(1);
                end else if (bank_ext) begin
                    tcnt_nx  = '0;
                    state_nx = S_WAIT_EXT;
                end else begin
                    if (!is_write) begin
                        data_out_nx = sel_data;
                    end
                    state_nx = S_DONE;
                end
            end
            S_WAIT_EXT: begin
                // Device ready takes priority over a coincident timeout
                if (bank_ready[bank]) begin
                    if (!is_write) begin
                        data_out_nx = sel_data;
                    end
                    state_nx = S_DONE;
                end else if ((TIMEOUT != 0) && (tcnt == TO_W'(TIMEOUT - 1))) begin
                    data_out_nx = '0;
                    err_nx      = 1'b1;
                    state_nx    = S_DONE;
                end else if (tcnt != '1) begin
                    tcnt_nx = tcnt + TO_W'(1);
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if ((state_nx == S_ACCESS) || (state_nx == S_WAIT_EXT)) begin
            select_nx = NUM_BANKS'(1) << bank_nx;
        end
        ready_nx     = (state_nx == S_DONE);
        bus_error_nx = (state_nx == S_DONE) && err_nx;
    end

    // State, latched request and registered outputs
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state             <= S_IDLE;
            bank              <= '0;
            is_write          <= 1'b0;
            addr_q            <= '0;
            data_q            <= '0;
            mask_q            <= '0;
            wait_cnt          <= '0;
            tcnt              <= '0;
            err               <= 1'b0;
            data_out          <= '0;
            ready             <= 1'b0;
            bus_error         <= 1'b0;
            bank_select       <= '0;
            bank_write_enable <= '0;
        end else begin
            state             <= state_nx;
            bank              <= bank_nx;
            is_write          <= is_write_nx;
            addr_q            <= addr_nx;
            data_q            <= data_nx;
            mask_q            <= mask_nx;
            wait_cnt          <= wait_nx;
            tcnt              <= tcnt_nx;
            err               <= err_nx;
            data_out          <= data_out_nx;
            ready             <= ready_nx;
            bus_error         <= bus_error_nx;
            bank_select       <= select_nx;
            bank_write_enable <= strobe_nx;
        end
    end

endmodule

// File: tb/tb_memory_bus_ws.sv
// Directed bench for memory_bus_ws with TIMEOUT = 8 and default bank setup.
module tb_memory_bus_ws;

    logic         raw_clk = 1'b0;
    logic         reset;
    logic [15:0]  address;
    logic [31:0]  data_in;
    logic [3:0]   write_mask;
    logic         write_enable;
    logic         bus_enable;
    logic [31:0]  data_out;
    logic         ready;
    logic         bus_error;
    logic [13:0]  bank_address;
    logic [31:0]  bank_data_in;
    logic [3:0]   bank_write_mask;
    logic [3:0]   bank_select;
    logic [3:0]   bank_write_enable;
    logic [127:0] bank_data_out;
    logic [3:0]   bank_ready;

    logic [31:0]  bank0_q;
    logic [31:0]  bank2_data;
    logic [7:0]   ready_trace;

    int checks = 0;
    int errors = 0;

    memory_bus_ws #(.TIMEOUT(8)) dut (
        .raw_clk           (raw_clk),
        .reset             (reset),
        .address           (address),
        .data_in           (data_in),
        .write_mask        (write_mask),
        .write_enable      (write_enable),
        .bus_enable        (bus_enable),
        .data_out          (data_out),
        .ready             (ready),
        .bus_error         (bus_error),
        .bank_address      (bank_address),
        .bank_data_in      (bank_data_in),
        .bank_write_mask   (bank_write_mask),
        .bank_select       (bank_select),
        .bank_write_enable (bank_write_enable),
        .bank_data_out     (bank_data_out),
        .bank_ready        (bank_ready)
    );

    always #5 raw_clk = ~raw_clk;

    // Bank 0: synchronous RAM returning a fixed word one cycle after select
    always @(posedge raw_clk) begin
        bank0_q <= bank_select[0] ? 32'h12345678 : 32'h0;
    end

    assign bank_data_out = {32'h0, bank2_data, 32'h0, bank0_q};

    task automatic tick();
        @(posedge raw_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        address      = '0;
        data_in      = '0;
        write_mask   = '0;
        write_enable = 1'b0;
        bus_enable   = 1'b0;
        bank_ready   = '0;
        bank2_data   = '0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and idle behaviour
        chk("rst_data_out", 64'(data_out), 64'h0);
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_bus_error", 64'(bus_error), 64'h0);
        chk("rst_select", 64'(bank_select), 64'h0);
        chk("rst_bwe", 64'(bank_write_enable), 64'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ready_select", {ready, bank_select}, 64'h0);
        end

        // Read bank 0, latency 1: ready three edges after request
        address    = 16'h0010;
        bus_enable = 1'b1;
        tick();
        chk("rd0_select", 64'(bank_select), 64'h1);
        chk("rd0_bank_addr", 64'(bank_address), 64'h0010);
        chk("rd0_ready_e0", 64'(ready), 64'h0);
        tick();
        chk("rd0_ready_e1", {ready, bank_select}, 64'h01);
        tick();
        chk("rd0_ready", 64'(ready), 64'h1);
        chk("rd0_data", 64'(data_out), 64'h12345678);
        chk("rd0_err", 64'(bus_error), 64'h0);
        chk("rd0_select_done", 64'(bank_select), 64'h0);
        bus_enable = 1'b0;
        tick();
        chk("rd0_ready_after", 64'(ready), 64'h0);

        // Write bank 3: single strobe, latched mask and data
        address      = 16'hC004;
        data_in      = 32'hA5A5A5A5;
        write_mask   = 4'b0011;
        write_enable = 1'b1;
        bus_enable   = 1'b1;
        tick();
        chk("wr3_bwe_first", 64'(bank_write_enable), 64'h8);
        chk("wr3_select", 64'(bank_select), 64'h8);
        chk("wr3_mask", 64'(bank_write_mask), 64'h3);
        chk("wr3_data", 64'(bank_data_in), 64'hA5A5A5A5);
        chk("wr3_addr", 64'(bank_address), 64'h0004);
        data_in = 32'h0;   // changes outside IDLE must not leak through
        tick();
        chk("wr3_bwe_second", 64'(bank_write_enable), 64'h0);
        chk("wr3_data_held", 64'(bank_data_in), 64'hA5A5A5A5);
        chk("wr3_ready_e1", 64'(ready), 64'h0);
        tick();
        chk("wr3_ready", 64'(ready), 64'h1);
        chk("wr3_err", 64'(bus_error), 64'h0);
        chk("wr3_bwe_done", 64'(bank_write_enable), 64'h0);
        chk("wr3_data_out_hold", 64'(data_out), 64'h12345678);
        bus_enable   = 1'b0;
        write_enable = 1'b0;
        tick();
        chk("wr3_ready_after", {ready, bank_write_enable}, 64'h0);

        // Bank 2 external-ready read, ready in the 5th WAIT_EXT cycle
        address    = 16'h8020;
        bank2_data = 32'hCAFEF00D;
        bus_enable = 1'b1;
        tick();
        chk("ext_select_e0", 64'(bank_select), 64'h4);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ext_wait", {ready, bank_select}, 64'h04);
        end
        bank_ready = 4'b0100;
        tick();
        chk("ext_ready", 64'(ready), 64'h1);
        chk("ext_data", 64'(data_out), 64'hCAFEF00D);
        chk("ext_err", 64'(bus_error), 64'h0);
        bus_enable = 1'b0;
        bank_ready = 4'b0000;
        tick();
        chk("ext_ready_after", 64'(ready), 64'h0);

        // Bank 2 with no device ready: timeout after 8 WAIT_EXT cycles
        address    = 16'h8000;
        bank2_data = 32'hDEADBEEF;
        bus_enable = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("to_wait", {bus_error, ready}, 64'h0);
        end
        tick();
        chk("to_ready_err", {ready, bus_error}, 64'h3);
        chk("to_data_zero", 64'(data_out), 64'h0);
        chk("to_select_done", 64'(bank_select), 64'h0);
        bus_enable = 1'b0;
        tick();
        chk("to_after", {ready, bus_error}, 64'h0);

        // Reset during ACCESS of a write aborts it
        address      = 16'h0008;
        data_in      = 32'h11111111;
        write_enable = 1'b1;
        bus_enable   = 1'b1;
        tick();
        chk("rsta_bwe", 64'(bank_write_enable), 64'h1);
        reset        = 1'b1;
        bus_enable   = 1'b0;
        write_enable = 1'b0;
        tick();
        reset = 1'b0;
        chk("rsta_cleared", {ready, bank_select, bank_write_enable}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rsta_quiet", {ready, bank_select, bank_write_enable}, 64'h0);
        end

        // Reset during WAIT_EXT aborts it
        address    = 16'h8000;
        bus_enable = 1'b1;
        tick();
        tick();
        tick();
        chk("rstw_in_wait", 64'(bank_select), 64'h4);
        reset      = 1'b1;
        bus_enable = 1'b0;
        tick();
        reset = 1'b0;
        chk("rstw_cleared", {ready, bus_error, bank_select}, 64'h0);
        chk("rstw_data", 64'(data_out), 64'h0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rstw_quiet", {ready, bus_error, bank_select}, 64'h0);
        end

        // Normal access after reset abort
        address    = 16'h0010;
        bus_enable = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_ready", 64'(ready), 64'h1);
        chk("post_rst_data", 64'(data_out), 64'h12345678);
        bus_enable = 1'b0;
        tick();

        // Back-to-back: bus_enable held high gives two separate pulses
        address    = 16'h0020;
        bus_enable = 1'b1;
        ready_trace = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            ready_trace[i] = ready;
        end
        bus_enable = 1'b0;
        chk("b2b_ready_trace", 64'(ready_trace), 64'h44);
        tick();
        tick();
        chk("b2b_idle", {ready, bank_select}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
